// File: rtl/demux_deserializer.sv
// demux_deserializer: collects a 1-bit serial stream, LSB first, into an N-bit word.
// The next-slot counter is decoded one-hot to produce a per-slot load enable.
// A completed word is held on a valid/ready port until the consumer takes it.
// A bit may be accepted in the same cycle that the finished word is consumed, so words stream with no bubble.
module demux_deserializer #(
  parameter int N = 4,
  parameter int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [S-1:0] count
);

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  state_t         state, state_n;
  logic [S-1:0]   count_n;
  logic [N-1:0]   data_n;
  logic [N-1:0]   slot_sel;
  logic [N-1:0]   slot_en;
  logic           accept;
  logic           consume;
  logic           last_slot;

  // Handshake decode. in_ready depends only on the state and out_ready, never on in_valid.
  always_comb begin
    in_ready  = (state == COLLECT) | out_ready;
    accept    = in_valid & in_ready;
    consume   = (state == FULL) & out_ready;
    last_slot = (count == S'(N - 1));
  end

  // One-hot demux of the slot counter. It gates the load enable of each slot while collecting.
  always_comb begin
    slot_sel = '0;
    slot_en  = '0;
    for (int k = 0; k < N; k++) begin
      slot_sel[k] = (count == S'(k));
      slot_en[k]  = slot_sel[k] & accept & (state == COLLECT);
    end
  end

  // Next-state logic. clear wins over everything; a FULL word is dropped only on consume or clear.
  always_comb begin
    state_n = state;
    count_n = count;
    data_n  = out_data;
    if (clear) begin
      state_n = COLLECT;
      count_n = '0;
      data_n  = '0;
    end else if (state == COLLECT) begin
      for (int k = 0; k < N; k++) begin
        if (slot_en[k]) data_n[k] = d;
      end
      if (accept) begin
        if (last_slot) begin
          count_n = '0;
          state_n = FULL;
        end else begin
          count_n = count + S'(1);
        end
      end
    end else if (consume) begin
      state_n = COLLECT;
      if (in_valid) begin
        data_n  = {{(N-1){1'b0}}, d};
        count_n = S'(1);
      end else begin
        data_n  = '0;
        count_n = '0;
      end
    end
  end

  // State, counter and word registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= COLLECT;
      count    <= '0;
      out_data <= '0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      out_data <= data_n;
    end
  end

  assign out_valid = (state == FULL);

endmodule
